uart_rx: RTL
============

# uart_rx

Asynchronous 8N1 serial receiver running directly on the 48 MHz USB PLL clock. It is the receive-side counterpart of the existing UART transmitter. It recovers bytes from an external serial pin and presents them through a small show-ahead FIFO with a valid/ready handshake. The demo logic drains it into the `usb_serial` TX path, so the board bridges UART to USB in both directions.

## Interface
- `CLKS_PER_BIT`, default 417: clk_48mhz cycles per bit (48 MHz / 115200, rounded); minimum 8.
- `FIFO_DEPTH`, default 4: receive FIFO entries; power of two, ≥2.
- `clk_48mhz`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `serial`  in  1  asynchronous RX line, idle high.
- `data`  out  8  head-of-FIFO byte; valid only while `valid`=1.
- `valid`  out  1  FIFO non-empty.
- `ready`  in  1  consumer accepts head when `valid`&&`ready`.
- `framing_error`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: good byte dropped, FIFO full.
- `busy`  out  1  receiver not in IDLE.

## Operation
- `serial` passes through a 2-FF synchronizer; sync regs reset to 1. All logic below uses the synchronized value `rx`.
- State WAIT_HIGH is the reset state:
  - Go to IDLE on the first cycle `rx`=1.
  - This covers lines held low, breaks, and post-error recovery.
- IDLE:
  - When `rx`=0, load the bit counter with CLKS_PER_BIT/2−1 (integer division) and go to START.
- START:
  - Count down to 0, then sample `rx`.
  - If `rx`=1, it is a glitch: go to IDLE, with no pulse.
  - If `rx`=0, load CLKS_PER_BIT−1, clear the bit index, and go to DATA.
- DATA:
  - At each counter expiry, shift `rx` into the shift register, LSB first, and reload the counter.
  - After the 8th sample, go to STOP.
- STOP, at counter expiry:
  - If `rx`=1, push the byte. If the FIFO is full and there is no pop in the same cycle, drop the byte and pulse `overrun`. Then go to IDLE.
  - If `rx`=0, pulse `framing_error`, discard the byte, and go to WAIT_HIGH.
- FIFO:
  - Show-ahead: `data` = head, `valid` = !empty.
  - Pop on `valid`&&`ready`.
  - A push and a pop in the same cycle when full are both accepted, with no overrun.
  - A push and a pop in the same cycle when empty make `valid` rise next cycle, with the pushed byte.
  - Pointers are log2(FIFO_DEPTH)+1 bits, with wrap-around via the MSB for full/empty.
- `ready` while `valid`=0 is ignored.

## Timing
- Reset values:
  - `valid`=0, `data`=0, `framing_error`=0, `overrun`=0, `busy`=0 (WAIT_HIGH counts as not busy).
  - FIFO empty, counter 0.
- Reset mid-frame aborts the frame with no pulse. The FIFO contents are lost.
- Start detection latency: 2 cycles (synchronizer) plus 1 cycle (IDLE→START).
- Samples fall at mid-bit: CLKS_PER_BIT/2 after the start edge, then every CLKS_PER_BIT. The stop bit is sampled at 9·CLKS_PER_BIT + CLKS_PER_BIT/2 after start detection.
- `valid` rises in the cycle after the stop-bit sample cycle; `data` is stable from that cycle until the pop.
- `framing_error` and `overrun` assert in the cycle after the stop sample, for exactly 1 cycle.
- Back-to-back frames are supported: IDLE is re-entered at mid-stop-bit, so the next start edge is caught with no gap requirement.
- Tolerated baud mismatch: ±4% at CLKS_PER_BIT ≥ 16.

## Structure
- The shared package holds:
  - The state enum (WAIT_HIGH, IDLE, START, DATA, STOP).
  - The 115200 default divisor constant, also used by the transmitter-side divider.
- One sub-module: `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty, show-ahead). It is reusable for the USB-side buffering.
- The receive FSM, counter, and shift register stay in `uart_rx`.

## Test plan
- Byte 0xA5 with CLKS_PER_BIT=16 and `ready`=1 → `valid` pulses one cycle with `data`=0xA5; no error pulses.
- Five frames 0x01..0x05 back-to-back with `ready`=0, FIFO_DEPTH=4:
  - `overrun` pulses once, on the 5th frame.
  - Then `ready`=1 pops 0x01..0x04 in order, and `valid` drops.
- 0x3C sent with the stop bit forced low, followed by the line held low for 40 cycles:
  - `framing_error` pulses once; no push; `busy`=0 while low.
  - Then 0x7E, sent once the line is high, is received correctly.
- Low glitch of 4 cycles on an idle line → no push and no error; state returns to IDLE.
- Reset asserted mid-DATA of 0x55 → all outputs 0. A following 0x99 is received correctly.
- With the FIFO full, `ready`=1 in the same cycle as the stop-bit push of 0x42 → no overrun; 0x42 is the last entry popped.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding and the default baud divisor.
// Imported by uart_rx and by the transmitter-side baud divider.
package uart_rx_pkg;

    // 48 MHz / 115200 baud, rounded to the nearest integer.
    localparam int unsigned CLKS_PER_BIT_115200 = 417;
    localparam int unsigned DATA_BITS           = 8;

    typedef enum logic [2:0] {
        WAIT_HIGH = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Show-ahead synchronous FIFO.
// Ports: i_clk, i_reset (sync, active-high), i_push/i_data write side,
//        i_pop/o_data read side (o_data is the head), o_full, o_empty.
// A push while full is accepted only when a pop happens in the same cycle;
// a pop while empty is ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer and storage update.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver on the 48 MHz clock with a show-ahead receive FIFO.
// Ports: clk_48mhz, reset (sync, active-high), serial (async RX, idle high),
//        data/valid/ready (FIFO head handshake), framing_error and overrun
//        (one-cycle pulses), busy (frame in progress).
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clk_48mhz,
    input  logic                 reset,
    input  logic                 serial,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    rx_state_t            r_state;
    rx_state_t            w_state_next;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [2:0]           r_idx;
    logic [2:0]           w_idx_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 r_framing_error;
    logic                 r_overrun;
    logic                 r_busy;
    logic                 w_rx;
    logic                 w_push;
    logic                 w_fe;
    logic                 w_ovr;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [DATA_BITS-1:0] w_fifo_data;

    assign w_rx          = r_sync2;
    assign valid         = !w_fifo_empty;
    assign data          = w_fifo_data;
    assign w_pop         = valid && ready;
    assign framing_error = r_framing_error;
    assign overrun       = r_overrun;
    assign busy          = r_busy;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= serial;
            r_sync2 <= r_sync1;
        end
    end

    // State, counter, shift register and registered status outputs.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            r_state         <= WAIT_HIGH;
            r_cnt           <= '0;
            r_idx           <= '0;
            r_shift         <= '0;
            r_framing_error <= 1'b0;
            r_overrun       <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_cnt           <= w_cnt_next;
            r_idx           <= w_idx_next;
            r_shift         <= w_shift_next;
            r_framing_error <= w_fe;
            r_overrun       <= w_ovr;
            r_busy          <= (w_state_next == START) || (w_state_next == DATA) ||
                               (w_state_next == STOP);
        end
    end

    // Receive FSM: each state waits for counter expiry, then samples rx.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_push       = 1'b0;
        w_fe         = 1'b0;
        w_ovr        = 1'b0;
        case (r_state)
            WAIT_HIGH: begin
                if (w_rx) begin
                    w_state_next = IDLE;
                end
            end
            IDLE: begin
                if (!w_rx) begin
                    w_cnt_next   = CNT_W'(CLKS_PER_BIT / 2 - 1);
                    w_state_next = START;
                end
            end
            START: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end else if (w_rx) begin
                    // Line back high at mid-start: treat as a glitch.
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next   = CNT_W'(CLKS_PER_BIT - 1);
                    w_idx_next   = '0;
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end else begin
                    w_shift_next = {w_rx, r_shift[DATA_BITS-1:1]};
                    w_cnt_next   = CNT_W'(CLKS_PER_BIT - 1);
                    if (r_idx == 3'd7) begin
                        w_state_next = STOP;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end else if (w_rx) begin
                    w_push       = 1'b1;
                    w_ovr        = w_fifo_full && !w_pop;
                    w_state_next = IDLE;
                end else begin
                    w_fe         = 1'b1;
                    w_state_next = WAIT_HIGH;
                end
            end
            default: w_state_next = WAIT_HIGH;
        endcase
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_48mhz),
        .i_reset (reset),
        .i_push  (w_push),
        .i_data  (w_shift_next),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

endmodule
